// File: rtl/req_capture_encoder_4_if.sv
// req_capture_encoder_4_if: request/grant bus between the capture encoder and its neighbours
interface req_capture_encoder_4_if #(parameter int DROP_CNT_W = 8);
    logic [3:0]            req_in;
    logic                  out_ready;
    logic                  clr_drop;
    logic                  out_valid;
    logic [1:0]            out_code;
    logic [3:0]            pending;
    logic [DROP_CNT_W-1:0] drop_cnt;
    modport master(output req_in, out_ready, clr_drop, input out_valid, out_code, pending, drop_cnt);
    modport slave(input req_in, out_ready, clr_drop, output out_valid, out_code, pending, drop_cnt);
endinterface

// File: rtl/req_capture_encoder_4.sv
// req_capture_encoder_4: captures request edges into a pending set and grants one line at a time (REQ_ROUND_ROBIN_EN selects round-robin instead of fixed priority)
module req_capture_encoder_4 #(
    parameter int DROP_CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    req_capture_encoder_4_if.slave bus
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t                state_q, state_d;
    logic [3:0]            req_prev, req_edge, pending_q, clr_vec, drops;
    logic [1:0]            code_q, sel;
    logic [2:0]            drop_num;
    logic [DROP_CNT_W+2:0] cnt_sum;
    logic [DROP_CNT_W-1:0] drop_q;
    logic                  hs;
    assign bus.out_valid = (state_q == PRESENT);
    assign bus.out_code  = code_q;
    assign bus.pending   = pending_q;
    assign bus.drop_cnt  = drop_q;
    assign hs       = (state_q == PRESENT) && bus.out_ready;
    assign req_edge = bus.req_in & ~req_prev;
    assign clr_vec  = hs ? 4'(1) << code_q : 4'b0000;
    assign drops    = req_edge & pending_q & ~clr_vec;
    assign drop_num = 3'(drops[0]) + 3'(drops[1]) + 3'(drops[2]) + 3'(drops[3]);
    assign cnt_sum  = {3'b000, drop_q} + {DROP_CNT_W'(0), drop_num};
`ifdef REQ_ROUND_ROBIN_EN
    logic [1:0] ptr_q;
    // rotate priority: nearest set line after the last granted one wins
    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (pending_q[ptr_q + 2'(i + 1)]) sel = ptr_q + 2'(i + 1);
    end
    // remember the last granted line so the next search starts after it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= 2'd3;
        else if (hs) ptr_q <= code_q;
`else
    // fixed priority: highest-numbered pending line wins
    always_comb begin
        sel = 2'd0;
        for (int i = 0; i < 4; i++)
            if (pending_q[i]) sel = 2'(i);
    end
`endif
    // next state: grant from the registered pending set, release on handshake
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = (pending_q != 4'b0000) ? PRESENT : IDLE;
        else state_d = hs ? IDLE : PRESENT;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    // edge history, pending set (new edge beats same-cycle clear) and grant code
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            req_prev  <= 4'b0000;
            pending_q <= 4'b0000;
            code_q    <= 2'b00;
        end else begin
            req_prev  <= bus.req_in;
            pending_q <= (pending_q & ~clr_vec) | req_edge;
            if (state_q == IDLE && pending_q != 4'b0000) code_q <= sel;
        end
    // saturating drop counter; clear wins over simultaneous drops
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) drop_q <= '0;
        else if (bus.clr_drop) drop_q <= '0;
        else drop_q <= (cnt_sum > {3'b000, {DROP_CNT_W{1'b1}}}) ? {DROP_CNT_W{1'b1}} : cnt_sum[DROP_CNT_W-1:0];
endmodule

// File: tb/tb_req_capture_encoder_4.sv
// tb_req_capture_encoder_4: scenario tasks with a grant-order scoreboard for req_capture_encoder_4
module tb_req_capture_encoder_4;
    logic clk, rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] exp_q[$];
    req_capture_encoder_4_if #(.DROP_CNT_W(2)) bus();
    req_capture_encoder_4 #(.DROP_CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drain(input int n);
        int got = 0;
        int budget = 40;
        logic [1:0] e;
        while (got < n && budget > 0) begin
            if (bus.out_valid && bus.out_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.out_code !== e) begin
                    errors++;
                    $display("FAIL grant_order got %0d expected %0d", bus.out_code, e);
                end
                got++;
            end
            step();
            budget--;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL grant_timeout got %0d grants expected %0d", got, n);
            exp_q.delete();
        end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_in = 4'b1111;
        bus.out_ready = 1'b0;
        bus.clr_drop = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus.out_valid, bus.out_code, bus.pending, bus.drop_cnt} !== 9'b0) begin
            errors++;
            $display("FAIL reset_values valid=%b code=%0d pending=%b drop=%0d expected all zero", bus.out_valid, bus.out_code, bus.pending, bus.drop_cnt);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.pending !== 4'b1111 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release pending=%b valid=%b expected 1111 0", bus.pending, bus.out_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_latency valid=%b expected 1", bus.out_valid);
        end
        bus.req_in = 4'b0000;
        bus.out_ready = 1'b1;
`ifdef REQ_ROUND_ROBIN_EN
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
`else
        exp_q = '{2'd3, 2'd2, 2'd1, 2'd0};
`endif
        drain(4);
        checks++;
        if (bus.pending !== 4'b0000 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL all_four_done pending=%b valid=%b expected 0000 0", bus.pending, bus.out_valid);
        end
    endtask
    task automatic test_reraise();
        bus.req_in = 4'b1001;
`ifdef REQ_ROUND_ROBIN_EN
        exp_q = '{2'd0, 2'd3};
`else
        exp_q = '{2'd3, 2'd0};
`endif
        step();
        bus.req_in = 4'b0000;
        drain(2);
    endtask
    task automatic test_single();
        bus.req_in = 4'b0100;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.pending !== 4'b0100 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_capture pending=%b valid=%b expected 0100 0", bus.pending, bus.out_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_code !== 2'd2) begin
            errors++;
            $display("FAIL single_grant valid=%b code=%0d expected 1 2", bus.out_valid, bus.out_code);
        end
        bus.req_in = 4'b0000;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.pending !== 4'b0000) begin
            errors++;
            $display("FAIL single_done valid=%b pending=%b expected 0 0000", bus.out_valid, bus.pending);
        end
    endtask
    task automatic test_backpressure();
        bus.clr_drop = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.clr_drop = 1'b0;
        bus.req_in = 4'b0010;
        step();
        bus.req_in = 4'b0000;
        step();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_code !== 2'd1) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d valid=%b code=%0d expected 1 1", c, bus.out_valid, bus.out_code);
            end
            bus.req_in = (c == 2 || c == 5) ? 4'b0010 : 4'b0000;
            step();
        end
        checks++;
        if (bus.drop_cnt !== 2'd2) begin
            errors++;
            $display("FAIL backpressure_drops got %0d expected 2", bus.drop_cnt);
        end
        bus.out_ready = 1'b1;
        exp_q.push_back(2'd1);
        drain(1);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.out_valid !== 1'b0 || bus.pending !== 4'b0000) begin
                errors++;
                $display("FAIL backpressure_single valid=%b pending=%b expected 0 0000", bus.out_valid, bus.pending);
            end
            step();
        end
    endtask
    task automatic test_same_cycle();
        bus.clr_drop = 1'b1;
        bus.out_ready = 1'b0;
        bus.req_in = 4'b0100;
        step();
        bus.clr_drop = 1'b0;
        bus.req_in = 4'b0000;
        step();
        bus.out_ready = 1'b1;
        bus.req_in = 4'b0100;
        step();
        checks++;
        if (bus.pending !== 4'b0100 || bus.out_valid !== 1'b0 || bus.drop_cnt !== 2'd0) begin
            errors++;
            $display("FAIL edge_and_clear pending=%b valid=%b drop=%0d expected 0100 0 0", bus.pending, bus.out_valid, bus.drop_cnt);
        end
        bus.req_in = 4'b0000;
        exp_q.push_back(2'd2);
        drain(1);
    endtask
    task automatic test_saturation();
        bus.out_ready = 1'b0;
        bus.req_in = 4'b0001;
        step();
        bus.req_in = 4'b0000;
        step();
        repeat (5) begin
            bus.req_in = 4'b0001;
            step();
            bus.req_in = 4'b0000;
            step();
        end
        checks++;
        if (bus.drop_cnt !== 2'd3) begin
            errors++;
            $display("FAIL drop_saturate got %0d expected 3", bus.drop_cnt);
        end
        bus.clr_drop = 1'b1;
        bus.req_in = 4'b0001;
        step();
        checks++;
        if (bus.drop_cnt !== 2'd0) begin
            errors++;
            $display("FAIL clear_wins got %0d expected 0", bus.drop_cnt);
        end
        bus.clr_drop = 1'b0;
        bus.req_in = 4'b0000;
        step();
        bus.req_in = 4'b1110;
        step();
        checks++;
        if (bus.drop_cnt !== 2'd0 || bus.pending !== 4'b1111) begin
            errors++;
            $display("FAIL fresh_no_drop drop=%0d pending=%b expected 0 1111", bus.drop_cnt, bus.pending);
        end
        bus.req_in = 4'b0000;
        step();
        bus.req_in = 4'b1111;
        step();
        checks++;
        if (bus.drop_cnt !== 2'd3) begin
            errors++;
            $display("FAIL multi_drop got %0d expected 3", bus.drop_cnt);
        end
        bus.req_in = 4'b0000;
        bus.out_ready = 1'b1;
`ifdef REQ_ROUND_ROBIN_EN
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
`else
        exp_q = '{2'd0, 2'd3, 2'd2, 2'd1};
`endif
        drain(4);
        checks++;
        if (bus.pending !== 4'b0000) begin
            errors++;
            $display("FAIL saturation_drained pending=%b expected 0000", bus.pending);
        end
    endtask
    task automatic test_reset_mid_grant();
        bus.out_ready = 1'b0;
        bus.req_in = 4'b1000;
        step();
        bus.req_in = 4'b0000;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_code !== 2'd3) begin
            errors++;
            $display("FAIL mid_grant_setup valid=%b code=%0d expected 1 3", bus.out_valid, bus.out_code);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.pending !== 4'b0000 || bus.out_code !== 2'd0) begin
            errors++;
            $display("FAIL async_reset valid=%b pending=%b code=%0d expected 0 0000 0", bus.out_valid, bus.pending, bus.out_code);
        end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.pending !== 4'b0000) begin
                errors++;
                $display("FAIL stale_grant valid=%b pending=%b expected 0 0000", bus.out_valid, bus.pending);
            end
        end
    endtask
    initial begin
        test_reset();
        test_reraise();
        test_single();
        test_backpressure();
        test_same_cycle();
        test_saturation();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
